seven_seg_scanner: RTL

Drives a 4-digit common-anode seven-segment display from a 14-bit binary value. On `load` it converts the value to four BCD digits with a sequential shift-add-3 converter. The converted digits are committed atomically, so the display never shows a partial update. It then time-multiplexes the digits onto the shared segment bus through one instance of the existing `seven_seg_decoder`. The block sits between core logic that produces a count/result and the board's anode/cathode pins.

---
 rtl/seven_seg_pkg.sv | 32 +++
 rtl/bin2bcd_seq.sv | 73 +++++++
 rtl/seven_seg_decoder.sv | 27 ++
 rtl/seven_seg_scanner.sv | 104 ++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the seven-segment display path.
package seven_seg_pkg;

    localparam int BIN_W      = 14;
    localparam int NUM_DIGITS = 4;

    localparam logic [BIN_W-1:0] MAX_VALUE = 14'd9999;

    // Active-low patterns, ordered {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } conv_state_t;

    // Shift-add-3 correction: every BCD nibble >= 5 gets 3 added before the shift
    function automatic logic [4*NUM_DIGITS-1:0] bcd_adjust(input logic [4*NUM_DIGITS-1:0] b);
        logic [4*NUM_DIGITS-1:0] r;
        r = b;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter: one shift-add-3 iteration per cycle, constant latency.
module bin2bcd_seq
    import seven_seg_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [BIN_W-1:0]        bin,
    output logic                    busy,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic                    ovf
);

    localparam logic [3:0] LAST_ITER = 4'(BIN_W - 1);

    conv_state_t             state;
    logic [BIN_W-1:0]        bin_sr;
    logic [4*NUM_DIGITS-1:0] bcd_sr;
    logic [4*NUM_DIGITS-1:0] bcd_adj;
    logic [3:0]              iter;
    logic                    ovf_next;

    // Nibble correction applied ahead of each shift
    always_comb begin
        bcd_adj = bcd_adjust(bcd_sr);
    end

    // Converter FSM; done is high for exactly the COMMIT cycle so bcd is final there
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bin_sr   <= '0;
            bcd_sr   <= '0;
            iter     <= '0;
            ovf_next <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        bin_sr   <= bin;
                        bcd_sr   <= '0;
                        iter     <= '0;
                        ovf_next <= (bin > MAX_VALUE);
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_sr <= {bcd_adj[4*NUM_DIGITS-2:0], bin_sr[BIN_W-1]};
                    bin_sr <= {bin_sr[BIN_W-2:0], 1'b0};
                    iter   <= iter + 4'd1;
                    if (iter == LAST_ITER) begin
                        done  <= 1'b1;
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bcd = bcd_sr;
    assign ovf = ovf_next;

endmodule

// File: rtl/seven_seg_decoder.sv
// BCD digit to active-low segment pattern {g,f,e,d,c,b,a}; non-BCD codes are unlit.
module seven_seg_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Pure lookup, no state
    always_comb begin
        seg = SEG_BLANK;
        unique case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// 4-digit common-anode display driver: converts a binary value to BCD on load, commits
// the digits atomically, and time-multiplexes them onto the shared segment bus.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BIN_W-1:0] value,
    input  logic             load,
    input  logic             blank_lz,
    output logic [3:0]       an,
    output logic [6:0]       seg,
    output logic             dp,
    output logic             busy,
    output logic             ovf
);

    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESCALE_TC = PW'(REFRESH_DIV - 1);

    logic [PW-1:0]                 prescaler;
    logic [1:0]                    index;
    logic [NUM_DIGITS-1:0][3:0]    d;
    logic                          conv_done;
    logic                          conv_ovf;
    logic [4*NUM_DIGITS-1:0]       conv_bcd;
    logic [3:0]                    cur_digit;
    logic [6:0]                    dec_seg;
    logic                          upper_zero;
    logic                          lz_blank;

    bin2bcd_seq u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (load),
        .bin   (value),
        .busy  (busy),
        .done  (conv_done),
        .bcd   (conv_bcd),
        .ovf   (conv_ovf)
    );

    seven_seg_decoder u_dec (
        .digit (cur_digit),
        .seg   (dec_seg)
    );

    // Digit registers and overflow flag change only on commit, so the display never tears
    always_ff @(posedge clk) begin
        if (rst) begin
            d   <= '0;
            ovf <= 1'b0;
        end else if (conv_done) begin
            d   <= conv_bcd;
            ovf <= conv_ovf;
        end
    end

    // Prescaler and digit index
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
            index     <= '0;
        end else if (prescaler == PRESCALE_TC) begin
            prescaler <= '0;
            index     <= index + 2'd1;
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

    // Leading-zero detection: this digit and everything to its left is zero
    always_comb begin
        cur_digit  = d[index];
        upper_zero = 1'b0;
        unique case (index)
            2'd0: upper_zero = 1'b0;
            2'd1: upper_zero = (d[3:1] == '0);
            2'd2: upper_zero = (d[3:2] == '0);
            2'd3: upper_zero = (d[3] == 4'd0);
            default: upper_zero = 1'b0;
        endcase
        lz_blank = blank_lz && !ovf && (index != 2'd0) && upper_zero;
    end

    // Output register: an and seg always move together on one edge
    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
        end else if (lz_blank) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
        end else begin
            an  <= ~(4'b0001 << index);
            seg <= ovf ? SEG_DASH : dec_seg;
        end
    end

    assign dp = 1'b1;

endmodule
